adc_axis_capture: RTL and testbench
===================================

// Module: adc_axis_capture
// PURPOSE
//  Parametrised ADC-to-AXI4-Stream capture front end; successor to the free-running 8-bit ADC streamer.
//  Subtracts an offset, arms on request and starts a packet on a software-selected trigger
//  (free-run / rising / falling level crossing). Buffers samples in a FIFO that honours tready.
//  Counts dropped samples. Sits between the ADC pins and the DMA/FFT stream path.
// PARAMETERS
//  DATA_W      8   ADC sample width (bits); also width of offset, trig_level, tdata
//  FIFO_DEPTH  16  output FIFO entries (power of 2, >=4)
//  CNT_W       16  packet length counter width
// PORTS
//  aclk         in   1       single clock; ADC_CLK is driven from it
//  aresetn      in   1       synchronous reset, active-low
//  ADC_CLK      out  1       = aclk (combinational pass-through)
//  ADC_Data     in   DATA_W  raw ADC sample, valid every aclk cycle
//  Offset       in   DATA_W  subtracted from each sample
//  pkt_len      in   CNT_W   packet length minus 1 (0 -> 1 sample); latched on arm
//  trig_mode    in   2       0 free-run, 1 rising, 2 falling, 3 reserved (= free-run)
//  trig_level   in   DATA_W  trigger threshold (unsigned compare on offset-corrected sample)
//  continuous   in   1       1: re-arm automatically after each packet
//  arm          in   1       1-cycle pulse; honoured only in IDLE
//  m_axis_tdata   out DATA_W  sample
//  m_axis_tvalid  out 1       FIFO not empty
//  m_axis_tready  in  1       consumer ready
//  m_axis_tlast   out 1       last sample of packet
//  busy         out  1       state != IDLE
//  drop_cnt     out  16      dropped-sample count, saturates at 16'hFFFF
//  last_lost    out  1       sticky: a tlast sample was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (aresetn=0 at edge): state IDLE, FIFO empty, tvalid=0, tdata=0, tlast=0, busy=0,
//   drop_cnt=0, last_lost=0, sample regs=0. Reset mid-packet discards FIFO contents and the packet.
//  Sample path:
//   - s = ADC_Data - Offset, modulo 2^DATA_W; no saturation.
//   - s is registered into s_cur every cycle; the previous s_cur moves into s_prev.
//  FSM:
//   - IDLE -> ARMED on arm; latches pkt_len and trig_mode; sets prev_ok=0.
//   - ARMED: prev_ok goes to 1 after the first s_cur in ARMED.
//     Trigger when:
//       free-run: any s_cur in ARMED (first cycle);
//       rising:   prev_ok & s_prev < trig_level & s_cur >= trig_level;
//       falling:  prev_ok & s_prev >= trig_level & s_cur < trig_level.
//     On trigger, s_cur is sample 0 of the packet; the FSM enters CAPTURE the same cycle.
//   - CAPTURE: one sample per cycle. Index counts 0..pkt_len_latched; the sample at index == pkt_len
//     carries tlast. After it: continuous=1 -> ARMED (prev_ok=0), else IDLE.
//   - arm outside IDLE is ignored. trig_mode, pkt_len and Offset changes outside IDLE do not affect
//     the current packet (mode/len are latched); an Offset change takes effect on the next sample.
//  FIFO:
//   - Show-ahead; stores {tlast, data}.
//   - Write decision uses the occupancy before any same-cycle pop.
//   - Non-last sample: written if occ < FIFO_DEPTH-1, else dropped.
//   - tlast sample: written if occ < FIFO_DEPTH, else dropped and last_lost set.
//   - Every drop increments drop_cnt (saturating). The index always advances, so packet length and
//     timing are preserved.
//   - Pop on tvalid & tready. Simultaneous push/pop keeps occupancy unchanged.
//   - tdata/tlast are stable while tvalid & !tready; tdata/tlast = 0 when tvalid=0.
//  Latency: sample present at ADC_Data before edge E0 (with trigger met) is written at E1;
//   tvalid=1 after E1.
// TESTING
//  T1 reset: aresetn=0 for 3 cycles with tready=1 -> tvalid=0, busy=0, drop_cnt=0, ADC_CLK follows aclk.
//  T2 free-run: Offset=8'h10, ADC_Data ramp 8'h10.., pkt_len=3, arm -> tdata 00,01,02,03;
//     tlast on 03 only; busy=0 afterwards.
//  T3 rising edge: trig_level=8'h80, Offset=0, samples 7E,7F,80,81, pkt_len=1 -> packet {80,81};
//     7F->80 is the crossing. Arming while 90 is present then 91: no trigger.
//  T4 backpressure: FIFO_DEPTH=16, pkt_len=31, tready=0 -> 15 samples stored;
//     indices 15..30 dropped (drop_cnt=16); tlast sample 31 stored in slot 16, last_lost=0;
//     then tready=1 -> 16 beats, tlast on final beat.
//  T5 lost last: repeat T4 with continuous=1 and tready=0 throughout -> second packet's tlast dropped,
//     last_lost=1, drop_cnt=16+32=48.
//  T6 reset mid-packet: aresetn=0 at index 5 of an 8-sample packet -> FIFO empty, tvalid=0;
//     a new arm after release produces a clean 8-sample packet.

Source files
------------

// File: rtl/adc_axis_capture_if.sv
// AXI4-Stream sample bus between the ADC capture front end and the stream consumer.
// Handshake: a beat transfers on a rising aclk edge where tvalid & tready are both 1; while tvalid=1 and tready=0
// the master holds tdata/tlast stable, tvalid never depends on tready, and tdata/tlast read as 0 when tvalid=0.
interface adc_axis_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_axis_capture.sv
// ADC capture front end: offset correction, armed level/free-run trigger, fixed-length packets
// pushed into a show-ahead FIFO on an AXI4-Stream master, with drop accounting under backpressure.
module adc_axis_capture #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    output logic              ADC_CLK,
    input  logic [DATA_W-1:0] ADC_Data,
    input  logic [DATA_W-1:0] Offset,
    input  logic [CNT_W-1:0]  pkt_len,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              continuous,
    input  logic              arm,
    adc_axis_capture_if.master m_axis,
    output logic              busy,
    output logic [15:0]       drop_cnt,
    output logic              last_lost,
    output logic [1:0]        dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_LAST_FREE = (AW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  s_cur, s_prev;
    logic [CNT_W-1:0]   len_q, idx;
    logic [1:0]         mode_q;
    logic               prev_ok;
    logic               trig, push, push_last, wr_en, drop, pop;

    logic [DATA_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        occ;

    assign ADC_CLK   = aclk;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        trig      = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                case (mode_q)
                    2'd1:    trig = prev_ok && (s_prev < trig_level) && (s_cur >= trig_level);
                    2'd2:    trig = prev_ok && (s_prev >= trig_level) && (s_cur < trig_level);
                    default: trig = 1'b1;
                endcase
                if (trig) begin
                    push      = 1'b1;
                    push_last = (len_q == '0);
                    if (push_last) state_nxt = continuous ? S_ARMED : S_IDLE;
                    else           state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push      = 1'b1;
                push_last = (idx == len_q);
                if (push_last) state_nxt = continuous ? S_ARMED : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // prev_ok only survives a cycle spent waiting in ARMED; every re-entry to ARMED starts at 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            s_cur   <= '0;
            s_prev  <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            idx     <= '0;
            prev_ok <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_cur   <= ADC_Data - Offset;
            s_prev  <= s_cur;
            prev_ok <= (state == S_ARMED) && !trig;
            if (state == S_IDLE && arm) begin
                len_q  <= pkt_len;
                mode_q <= trig_mode;
            end
            if (state == S_ARMED && trig) idx <= CNT_W'(1);
            else if (state == S_CAPTURE)  idx <= idx + 1'b1;
        end
    end

    // The last FIFO slot is reserved for the tlast sample so a packet boundary survives an overflow.
    assign pop   = m_axis.tvalid && m_axis.tready;
    assign wr_en = push && (push_last ? (occ < OCC_FULL) : (occ < OCC_LAST_FREE));
    assign drop  = push && !wr_en;

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {push_last, s_cur};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            drop_cnt  <= '0;
            last_lost <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (drop && push_last) last_lost <= 1'b1;
        end
    end

    assign m_axis.tvalid = (occ != '0);
    assign {m_axis.tlast, m_axis.tdata} = m_axis.tvalid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_adc_axis_capture.sv
// Self-checking bench for adc_axis_capture: directed tables and sequences plus a randomized run
// compared every cycle against a queue-based packet/FIFO reference model.
module tb_adc_axis_capture;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              adc_clk;
    logic [DATA_W-1:0] adc_data = '0;
    logic [DATA_W-1:0] offset = '0;
    logic [CNT_W-1:0]  pkt_len = '0;
    logic [1:0]        trig_mode = '0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              continuous = 1'b0;
    logic              arm = 1'b0;
    logic              busy;
    logic [15:0]       drop_cnt;
    logic              last_lost;
    logic [1:0]        dbg_state;

    adc_axis_capture_if #(.DATA_W(DATA_W)) m_axis ();

    adc_axis_capture #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .ADC_CLK    (adc_clk),
        .ADC_Data   (adc_data),
        .Offset     (offset),
        .pkt_len    (pkt_len),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .continuous (continuous),
        .arm        (arm),
        .m_axis     (m_axis),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .last_lost  (last_lost),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    bit mdl_on = 1'b0;

    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] got_q[$];
    logic [7:0]      seq_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        repeat (n) tick();
        aresetn = 1'b1;
    endtask

    task automatic arm_at(input logic [7:0] first);
        adc_data = first;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic ramp(input int n);
        for (int c = 0; c < n; c++) begin
            adc_data = adc_data + 8'd1;
            tick();
        end
    endtask

    task automatic drive_seq();
        for (int c = 0; c < seq_q.size(); c++) begin
            adc_data = seq_q[c];
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W:0] mq[$];
    int              m_drops = 0;
    bit              m_lost = 1'b0;
    logic [7:0]      m_cur = '0, m_prev = '0;
    bit              m_wait = 1'b0, m_seen = 1'b0;
    int              m_left = 0, m_len = 0;
    logic [1:0]      m_tm = '0;

    always @(posedge aclk) begin : model_p
        bit idle_b, has_s, s_last, trig;
        int occ;
        if (!aresetn) begin
            mq.delete();
            m_drops = 0;
            m_lost  = 1'b0;
            m_cur   = '0;
            m_prev  = '0;
            m_wait  = 1'b0;
            m_seen  = 1'b0;
            m_left  = 0;
        end else begin
            idle_b = !m_wait && (m_left == 0);
            occ    = mq.size();
            has_s  = 1'b0;
            s_last = 1'b0;
            trig   = 1'b0;
            if (m_wait) begin
                case (m_tm)
                    2'd1:    trig = m_seen && (m_prev < trig_level) && (m_cur >= trig_level);
                    2'd2:    trig = m_seen && (m_prev >= trig_level) && (m_cur < trig_level);
                    default: trig = 1'b1;
                endcase
                m_seen = 1'b1;
                if (trig) begin
                    m_wait = 1'b0;
                    m_left = m_len;
                    has_s  = 1'b1;
                    s_last = (m_len == 0);
                end
            end else if (m_left > 0) begin
                m_left--;
                has_s  = 1'b1;
                s_last = (m_left == 0);
            end
            if (m_axis.tready && occ > 0) void'(mq.pop_front());
            if (has_s) begin
                if (occ < (s_last ? FIFO_DEPTH : FIFO_DEPTH - 1)) mq.push_back({s_last, m_cur});
                else begin
                    if (m_drops < 65535) m_drops++;
                    if (s_last) m_lost = 1'b1;
                end
                if (s_last && continuous) begin
                    m_wait = 1'b1;
                    m_seen = 1'b0;
                end
            end
            if (idle_b && arm) begin
                m_wait = 1'b1;
                m_seen = 1'b0;
                m_len  = int'(pkt_len);
                m_tm   = trig_mode;
            end
            m_prev = m_cur;
            m_cur  = adc_data - offset;
        end
    end

    // ---------------- scoreboard: per-cycle model compare + beat monitor ----------------
    always @(negedge aclk) begin : sb_p
        logic [DATA_W:0] head;
        logic [15:0]     exp_drops;
        if (mdl_on) begin
            head = (mq.size() > 0) ? mq[0] : '0;
            exp_drops = m_drops[15:0];
            check("model", {4'd0, m_axis.tvalid, m_axis.tlast, m_axis.tdata, busy, last_lost, drop_cnt},
                  {4'd0, mq.size() > 0, head[8], head[7:0], m_wait || (m_left > 0), m_lost, exp_drops});
        end
        if (aresetn && m_axis.tvalid && m_axis.tready) got_q.push_back({m_axis.tlast, m_axis.tdata});
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  off;
        logic [7:0]  start;
        logic [15:0] len;
        logic [7:0]  exp_first;
        int          exp_beats;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{8'h10, 8'h10, 16'd3, 8'h00, 4};
        vt[1] = '{8'h05, 8'h02, 16'd0, 8'hFD, 1};
        vt[2] = '{8'h00, 8'hF0, 16'd5, 8'hF0, 6};
        vt[3] = '{8'hFF, 8'h00, 16'd2, 8'h01, 3};
        m_axis.tready = 1'b1;

        // T1 reset
        do_reset(3);
        mdl_on = 1'b1;
        @(negedge aclk);
        check("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_axis.tdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_last_lost", {31'd0, last_lost}, 32'd0);
        check("adc_clk_low", {31'd0, adc_clk}, 32'd0);
        @(posedge aclk);
        #1;
        check("adc_clk_high", {31'd0, adc_clk}, 32'd1);

        // T2 and table: free-run ramps
        for (int v = 0; v < 4; v++) begin
            offset = vt[v].off;
            pkt_len = vt[v].len;
            trig_mode = 2'd0;
            continuous = 1'b0;
            got_q.delete();
            exp_q.delete();
            arm_at(vt[v].start);
            ramp(int'(vt[v].len) + 6);
            wait_idle(50);
            for (int i = 0; i < vt[v].exp_beats; i++)
                exp_q.push_back({i == vt[v].exp_beats - 1, 8'(vt[v].exp_first + 8'(i))});
            compare_q($sformatf("freerun%0d", v));
        end

        // T3 rising edge, arming above the level first
        offset = 8'h00;
        trig_level = 8'h80;
        trig_mode = 2'd1;
        pkt_len = 16'd1;
        got_q.delete();
        exp_q.delete();
        arm_at(8'h90);
        seq_q = '{8'h91, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'h82, 8'h83, 8'h83, 8'h83};
        drive_seq();
        wait_idle(50);
        exp_q = '{{1'b0, 8'h80}, {1'b1, 8'h81}};
        compare_q("rising");

        // falling edge: 41->40 is not a crossing, 40->3F is
        trig_level = 8'h40;
        trig_mode = 2'd2;
        pkt_len = 16'd2;
        got_q.delete();
        arm_at(8'h50);
        seq_q = '{8'h45, 8'h41, 8'h40, 8'h3F, 8'h3E, 8'h3D, 8'h3C, 8'h3C, 8'h3C};
        drive_seq();
        wait_idle(50);
        exp_q = '{{1'b0, 8'h3F}, {1'b0, 8'h3E}, {1'b1, 8'h3D}};
        compare_q("falling");

        // T4 backpressure
        do_reset(2);
        trig_mode = 2'd0;
        pkt_len = 16'd31;
        m_axis.tready = 1'b0;
        arm_at(8'h00);
        ramp(40);
        wait_idle(50);
        check("bp_drop_cnt", {16'd0, drop_cnt}, 32'd16);
        check("bp_last_lost", {31'd0, last_lost}, 32'd0);
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 8'(i)});
        exp_q.push_back({1'b1, 8'd31});
        m_axis.tready = 1'b1;
        repeat (20) tick();
        compare_q("bp_drain");

        // T5 lost tlast in continuous mode
        do_reset(2);
        m_axis.tready = 1'b0;
        continuous = 1'b1;
        arm_at(8'h00);
        ramp(45);
        continuous = 1'b0;
        wait_idle(100);
        check("lost_drop_cnt", {16'd0, drop_cnt}, 32'd48);
        check("lost_last_lost", {31'd0, last_lost}, 32'd1);
        m_axis.tready = 1'b1;
        repeat (20) tick();

        // T6 reset mid-packet
        do_reset(2);
        m_axis.tready = 1'b0;
        pkt_len = 16'd7;
        arm_at(8'h00);
        ramp(5);
        do_reset(2);
        @(negedge aclk);
        check("midrst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        m_axis.tready = 1'b1;
        got_q.delete();
        exp_q.delete();
        #1;
        arm_at(8'h20);
        ramp(12);
        wait_idle(50);
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 8'(8'h20 + 8'(i))});
        compare_q("midrst_clean");

        // randomized run against the model
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            adc_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) offset = 8'($urandom);
            if ($urandom_range(0, 49) == 0) trig_level = 8'($urandom);
            trig_mode = 2'($urandom_range(0, 3));
            pkt_len = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 29) == 0) continuous = ~continuous;
            arm = ($urandom_range(0, 7) == 0);
            m_axis.tready = ((c / 200) % 2 == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
            aresetn = ($urandom_range(0, 999) != 0);
            tick();
        end
        aresetn = 1'b1;
        arm = 1'b0;
        continuous = 1'b0;
        m_axis.tready = 1'b1;
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
